// File: rtl/uart_frame_send.sv
// Framed multi-channel UART transmitter: HEADER, CHNUM*BYTENUM payload bytes, optional checksum.
// Start bit one cycle after capture; dataReady only in IDLE, so dataValid during a frame is ignored.
// Define UART_FRAME_CHECKSUM_EN to append the mod-256 payload sum as a trailing byte.
module uart_frame_send #(
  parameter int         CLKFREQ      = 100_000_000,
  parameter int         BAUDRATE     = 115200,
  parameter int         BYTENUM      = 7,
  parameter int         CHNUM        = 2,
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         LSBYTE_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHNUM*BYTENUM*8-1:0]   dataIn,
  input  logic                         dataValid,
  output logic                         dataReady,
  output logic                         uartTx,
  output logic                         busy,
  output logic                         dataTxDone
);

  localparam int BAUDDIV = CLKFREQ / BAUDRATE;
  localparam int NPAY    = CHNUM * BYTENUM;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NBYTES  = NPAY + 2;
`else
  localparam int NBYTES  = NPAY + 1;
`endif
  localparam int BCW = $clog2(NBYTES + 1);
  localparam int BDW = $clog2(BAUDDIV);

  localparam logic [BDW-1:0] BAUD_LAST = BDW'(BAUDDIV - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [BDW-1:0]    r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [BCW-1:0]    r_byte_cnt;
  logic [7:0]        r_shift;
  logic [NPAY*8-1:0] r_seq;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic [NPAY*8-1:0] w_seq;
  logic              w_baud_end;
  logic              w_capture;

  // Payload is reordered into transmit order at capture so the datapath only ever shifts.
  for (genvar j = 0; j < NPAY; j++) begin : g_seq
    localparam int CH  = j / BYTENUM;
    localparam int K   = j % BYTENUM;
    localparam int POS = (LSBYTE_FIRST != 0) ? K : (BYTENUM - 1 - K);
    assign w_seq[j*8 +: 8] = dataIn[(CH*BYTENUM + POS)*8 +: 8];
  end

  assign w_baud_end = (r_baud_cnt == BAUD_LAST);
  assign w_capture  = dataValid && dataReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_seq      <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_seq      <= w_seq;
            r_shift    <= HEADER;
            r_byte_cnt <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_sum      <= '0;
`endif
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_shift    <= r_shift >> 1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_byte_cnt == BYTE_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= S_START;
`ifdef UART_FRAME_CHECKSUM_EN
              // Byte index NPAY is the last payload byte; the one after it is the sum.
              if (r_byte_cnt == BCW'(NPAY)) begin
                r_shift <= r_sum;
              end else begin
                r_shift <= r_seq[7:0];
                r_seq   <= r_seq >> 8;
                r_sum   <= r_sum + r_seq[7:0];
              end
`else
              r_shift <= r_seq[7:0];
              r_seq   <= r_seq >> 8;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dataReady  = (r_state == S_IDLE);
  assign busy       = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign dataTxDone = (r_state == S_DONE);
  assign uartTx     = (r_state == S_START) ? 1'b0 :
                      (r_state == S_DATA)  ? r_shift[0] : 1'b1;

endmodule

// File: tb/tb_uart_frame_send.sv
// Bench for uart_frame_send: two instances (MS-first and LS-first) against a cycle-level frame model
// plus a UART line decoder; honours UART_FRAME_CHECKSUM_EN.
module tb_uart_frame_send;

  localparam int BAUD    = 10;
  localparam int BYTENUM = 2;
  localparam int CHNUM   = 2;
  localparam int NPAY    = BYTENUM * CHNUM;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 6;
  localparam logic [47:0] F1  = 48'hAA_AB_CD_12_34_BE;
  localparam logic [47:0] F1L = 48'hAA_CD_AB_34_12_BE;
  localparam logic [47:0] FA  = 48'hAA_BE_EF_DE_AD_38;
  localparam logic [47:0] FAL = 48'hAA_EF_BE_AD_DE_38;
  localparam logic [47:0] FB  = 48'hAA_FF_80_01_02_82;
  localparam logic [47:0] FBL = 48'hAA_80_FF_02_01_82;
  localparam int FLEN_LIT = 600;
`else
  localparam int NB = 5;
  localparam logic [47:0] F1  = 48'hAA_AB_CD_12_34_00;
  localparam logic [47:0] F1L = 48'hAA_CD_AB_34_12_00;
  localparam logic [47:0] FA  = 48'hAA_BE_EF_DE_AD_00;
  localparam logic [47:0] FAL = 48'hAA_EF_BE_AD_DE_00;
  localparam logic [47:0] FB  = 48'hAA_FF_80_01_02_00;
  localparam logic [47:0] FBL = 48'hAA_80_FF_02_01_00;
  localparam int FLEN_LIT = 500;
`endif
  localparam int FLEN = NB * 10 * BAUD;

  logic        clk = 1'b0;
  logic        reset;
  logic        dataValid;
  logic [31:0] dataIn;
  logic [1:0]  tx, rdy, bsy, dn;

  always #5 clk = ~clk;

  uart_frame_send #(.CLKFREQ(1_000_000), .BAUDRATE(100_000), .BYTENUM(BYTENUM), .CHNUM(CHNUM),
                    .HEADER(8'hAA), .LSBYTE_FIRST(0)) u_dut0 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(rdy[0]), .uartTx(tx[0]), .busy(bsy[0]), .dataTxDone(dn[0]));

  uart_frame_send #(.CLKFREQ(1_000_000), .BAUDRATE(100_000), .BYTENUM(BYTENUM), .CHNUM(CHNUM),
                    .HEADER(8'hAA), .LSBYTE_FIRST(1)) u_dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(rdy[1]), .uartTx(tx[1]), .busy(bsy[1]), .dataTxDone(dn[1]));

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          m_pos;
  logic [31:0] m_din;
  int          rx_t [2];
  logic [7:0]  rx_b [2];
  logic [7:0]  rx_q0 [$];
  logic [7:0]  rx_q1 [$];
  longint      cap_t, t_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Byte i of the frame: 0 is the header, 1..NPAY payload in send order, then the checksum.
  function automatic logic [7:0] frame_byte(input logic [31:0] din, input int ls, input int i);
    int j, idx;
    logic [7:0] s;
    if (i == 0) return 8'hAA;
    if (i <= NPAY) begin
      j   = i - 1;
      idx = (ls != 0) ? (j % BYTENUM) : (BYTENUM - 1 - j % BYTENUM);
      return din[((j / BYTENUM) * BYTENUM + idx) * 8 +: 8];
    end
    s = 8'h00;
    for (int b = 0; b < NPAY; b++) s = s + din[b*8 +: 8];
    return s;
  endfunction

  // Expected {uartTx, dataReady, busy, dataTxDone} for the current model position.
  function automatic logic [3:0] model_out(input int ls);
    int bitno, b;
    logic [7:0] by;
    logic line;
    if (m_pos < 0) return 4'b1100;
    if (m_pos == FLEN) return 4'b1001;
    bitno = m_pos / BAUD;
    b     = bitno % 10;
    by    = frame_byte(m_din, ls, bitno / 10);
    line  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : by[b-1];
    return {line, 3'b010};
  endfunction

  task automatic tick();
    int n;
    @(posedge clk);
    if (reset) m_pos = -1;
    else if (m_pos < 0) begin
      if (dataValid) begin m_pos = 0; m_din = dataIn; end
    end else if (m_pos == FLEN) m_pos = -1;
    else m_pos++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk((k == 0) ? "cycle_ms" : "cycle_ls", 32'({tx[k], rdy[k], bsy[k], dn[k]}), 32'(model_out(k)));
      if (reset) rx_t[k] = -1;
      else if (rx_t[k] < 0) begin
        if (tx[k] == 1'b0) rx_t[k] = 0;
      end else rx_t[k]++;
      if (rx_t[k] >= 0 && rx_t[k] % BAUD == BAUD / 2) begin
        n = rx_t[k] / BAUD;
        if (n >= 1 && n <= 8) rx_b[k][n-1] = tx[k];
        else if (n == 9) begin
          if (k == 0) rx_q0.push_back(rx_b[k]);
          else rx_q1.push_back(rx_b[k]);
          rx_t[k] = -1;
        end
      end
    end
    if (dn[0]) done_cnt++;
  endtask

  task automatic wait_done(output longint t);
    int n = 0;
    while (dn[0] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(dn[0]), 32'd1);
    t = $time;
  endtask

  task automatic check_frame(input int k, input logic [47:0] exp);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      if (k == 0) b = (rx_q0.size() > 0) ? rx_q0.pop_front() : 8'hxx;
      else        b = (rx_q1.size() > 0) ? rx_q1.pop_front() : 8'hxx;
      chk($sformatf("byte%0d_inst%0d", i, k), 32'(b), 32'(exp[47-8*i -: 8]));
    end
  endtask

  task automatic send_one(input logic [31:0] d);
    dataIn    = d;
    dataValid = 1'b1;
    cap_t     = $time + 5;
    tick();
    dataValid = 1'b0;
    wait_done(t_done);
    chk("latency", 32'((t_done - 5 - cap_t) / 10), 32'(FLEN_LIT));
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; dataValid = 1'b0; dataIn = '0; m_pos = -1; m_din = '0;
    rx_t[0] = -1; rx_t[1] = -1; rx_b[0] = '0; rx_b[1] = '0;

    repeat (5) tick();
    chk("rst_tx",   32'(tx),  32'd3);
    chk("rst_rdy",  32'(rdy), 32'd3);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_done", 32'(dn),  32'd0);
    reset = 1'b0;
    tick();

    // Single frame, both byte orders.
    send_one(32'h1234_ABCD);
    check_frame(0, F1);
    check_frame(1, F1L);

    // dataValid held high with dataIn changed mid-frame: back-to-back frames.
    dataIn    = 32'hDEAD_BEEF;
    dataValid = 1'b1;
    cap_t     = $time + 5;
    tick();
    repeat (150) tick();
    dataIn = 32'h0102_FF80;
    wait_done(t_done);
    chk("latency_a", 32'((t_done - 5 - cap_t) / 10), 32'(FLEN_LIT));
    tick();
    chk("recap_rdy", 32'(rdy[0]), 32'd1);
    tick();
    chk("recap_start", 32'(tx[0]), 32'd0);
    dataValid = 1'b0;
    cap_t     = $time - 5;
    wait_done(t_done);
    chk("latency_b", 32'((t_done - 5 - cap_t) / 10), 32'(FLEN_LIT));
    tick();
    tick();
    check_frame(0, FA);
    check_frame(1, FAL);
    check_frame(0, FB);
    check_frame(1, FBL);

    // Reset during the third byte, together with dataValid.
    done_cnt  = 0;
    dataIn    = 32'h1234_ABCD;
    dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
    repeat (250) tick();
    reset     = 1'b1;
    dataValid = 1'b1;
    tick();
    chk("abort_tx",   32'(tx),  32'd3);
    chk("abort_rdy",  32'(rdy), 32'd3);
    chk("abort_busy", 32'(bsy), 32'd0);
    reset     = 1'b0;
    dataValid = 1'b0;
    repeat (700) tick();
    chk("abort_nodone", 32'(done_cnt), 32'd0);
    chk("abort_rdy_after", 32'(rdy), 32'd3);
    rx_q0.delete();
    rx_q1.delete();

    send_one(32'h1234_ABCD);
    check_frame(0, F1);
    check_frame(1, F1L);
    chk("q0_empty", 32'(rx_q0.size()), 32'd0);
    chk("q1_empty", 32'(rx_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
